// File: rtl/din_arb_pkg.sv
// Shared types and helpers for the byte-stream arbiter.
// Holds FSM states, default widths and a round-robin pick helper.
package din_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 16;
  localparam int MAX_SRC       = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping within n sources.
  function automatic pick_t rr_pick(
    input logic [MAX_SRC-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    pick_t r;
    int    j;
    r = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (i < n) begin
        j = (int'(ptr) + i) % n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/din_stream_arbiter_if.sv
// Source-side and sink-side bundle of the byte-stream arbiter.
// master drives requests and downstream ready; slave is the arbiter.
interface din_stream_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_SRC);

  logic [N_SRC*DATA_W-1:0] s_data;
  logic [N_SRC-1:0]        s_vld;
  logic [N_SRC-1:0]        s_last;
  logic [N_SRC-1:0]        s_rdy;
  logic [DATA_W-1:0]       o_data_dout;
  logic                    o_data_dout_vld;
  logic                    o_data_dout_last;
  logic                    i_data_dout_rdy;
  logic [ID_W-1:0]         o_grant_id;
  logic                    o_busy;

  modport master (
    output s_data, s_vld, s_last, i_data_dout_rdy,
    input  s_rdy, o_data_dout, o_data_dout_vld,
    input  o_data_dout_last, o_grant_id, o_busy
  );

  modport slave (
    input  s_data, s_vld, s_last, i_data_dout_rdy,
    output s_rdy, o_data_dout, o_data_dout_vld,
    output o_data_dout_last, o_grant_id, o_busy
  );

endinterface

// File: rtl/din_rr_picker.sv
// Combinational round-robin picker: rotate by ptr, take lowest set
// bit, rotate the index back. Reusable by any shared-resource arbiter.
module din_rr_picker #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  localparam logic [ID_W:0] NS = (ID_W+1)'(N_SRC);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  always_comb begin
    dbl = {req, req};
    rot = N_SRC'(dbl >> ptr);
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= NS) sum = sum - NS;
    idx   = sum[ID_W-1:0];
    found = |req;
  end

endmodule

// File: rtl/din_stream_arbiter.sv
// Packet-aware round-robin arbiter onto one registered byte stream.
// Grant holds until last or MAX_BURST beats; output has ready/valid.
module din_stream_arbiter
  import din_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int ID_W      = $clog2(N_SRC)
) (
  input  logic                 dout_clk,
  input  logic                 rst_n,
  din_stream_arbiter_if.slave  bus
);

  localparam logic [7:0]      LAST_CNT = 8'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] TOP_ID   = ID_W'(N_SRC - 1);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic [7:0]        burst_cnt;
  logic [DATA_W-1:0] dout;
  logic              vld;
  logic              last;

  logic              room;
  logic              accept;
  logic              beat_last;
  logic              sel_vld;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [N_SRC-1:0]  rdy;

  din_rr_picker #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (bus.s_vld),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant == ID_W'(k)) begin
        sel_vld  = bus.s_vld[k];
        sel_last = bus.s_last[k];
        sel_data = bus.s_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Ready depends only on registered state and downstream ready.
  always_comb begin
    state_nxt = state;
    rdy       = '0;
    accept    = 1'b0;
    room      = ~vld | bus.i_data_dout_rdy;
    beat_last = sel_last | (burst_cnt == LAST_CNT);
    unique case (state)
      IDLE: begin
        if (found) state_nxt = GRANT;
      end
      GRANT: begin
        for (int k = 0; k < N_SRC; k++) begin
          rdy[k] = (grant == ID_W'(k)) & room;
        end
        accept = sel_vld & room;
        if (accept & beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dout_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge dout_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      grant     <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant     <= pick;
        burst_cnt <= '0;
      end
      if (accept) begin
        burst_cnt <= burst_cnt + 8'd1;
        if (beat_last) begin
          ptr <= (grant == TOP_ID) ? '0 : grant + ID_W'(1);
        end
      end
    end
  end

  always_ff @(posedge dout_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vld  <= 1'b0;
      last <= 1'b0;
    end else if (accept) begin
      dout <= sel_data;
      vld  <= 1'b1;
      last <= beat_last;
    end else if (bus.i_data_dout_rdy) begin
      vld  <= 1'b0;
      last <= 1'b0;
    end
  end

  assign bus.s_rdy            = rdy;
  assign bus.o_data_dout      = dout;
  assign bus.o_data_dout_vld  = vld;
  assign bus.o_data_dout_last = last;
  assign bus.o_grant_id       = grant;
  assign bus.o_busy           = (state == GRANT);

endmodule

// File: doc/din_stream_arbiter.md
Name: din_stream_arbiter

Overview:
- Round-robin arbiter that shares the single byte stream (data byte + valid, clocked by dout_clk) between N_SRC requesters, e.g. PE result ports.
- Packet-aware: a grant is held until the source asserts last or until MAX_BURST beats have been sent, whichever comes first.
- Provides a registered output stage with ready/valid backpressure. Exposes grant id and busy status for debug probing.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- DATA_W, 8, byte-stream data width.
- MAX_BURST, 16, maximum beats per grant before forced rotation (1..255).
- ID_W, $clog2(N_SRC), width of the grant id.

Ports:
- dout_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  N_SRC*DATA_W  source data; source k occupies bits [k*DATA_W +: DATA_W].
- s_vld  in  N_SRC  source beat valid.
- s_last  in  N_SRC  source last beat of packet; qualified by s_vld.
- s_rdy  out  N_SRC  source beat accepted when s_vld[k] & s_rdy[k].
- o_data_dout  out  DATA_W  arbitrated byte.
- o_data_dout_vld  out  1  output valid.
- o_data_dout_last  out  1  last beat of the current grant: packet end or forced burst end.
- i_data_dout_rdy  in  1  downstream ready.
- o_grant_id  out  ID_W  currently or last granted source.
- o_busy  out  1  high while in the GRANT state.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - o_data_dout = 0, o_data_dout_vld = 0, o_data_dout_last = 0.
  - s_rdy = 0, o_grant_id = 0, o_busy = 0.
  - Priority pointer = 0, burst counter = 0, state = IDLE.
- FSM states are IDLE and GRANT.
- IDLE:
  - If any s_vld bit is set, pick the first set bit searching from ptr upward with wrap-around (ptr, ptr+1, …, N_SRC-1, 0, …).
  - Register the winner into o_grant_id, clear the burst counter, go to GRANT.
  - s_rdy is all zero in IDLE.
  - Result: one bubble cycle per arbitration.
- GRANT:
  - s_rdy[g] = (~o_data_dout_vld | i_data_dout_rdy); all other s_rdy bits are 0.
  - The rdy path is combinational from registered state and i_data_dout_rdy only, never from s_vld.
- Accepted beat (s_vld[g] & s_rdy[g]):
  - Load the output register with s_data[g] on the next edge and set vld = 1.
  - last = s_last[g] | (burst_cnt == MAX_BURST-1).
  - Increment burst_cnt.
  - Latency is 1 cycle from acceptance to output.
- Output register:
  - Holds its value while vld & ~i_data_dout_rdy.
  - vld clears on the cycle it is consumed with no new accepted beat.
- Release:
  - Triggered on the cycle the beat that set last is accepted.
  - Go to IDLE, set ptr = g+1 (wrapping N_SRC-1 to 0), o_busy falls.
  - The pending output beat drains independently.
- Source drops s_vld mid-packet: the grant is held with no timeout. Ownership is released only by last or MAX_BURST.
- Simultaneous requests: strictly round-robin. After source g is served it has lowest priority.
- MAX_BURST = 1: every beat carries last, giving a beat-level round-robin.
- Backpressure:
  - While the output register is full and not ready, s_rdy is 0.
  - No beat is dropped or duplicated.
- s_data of non-granted sources is ignored. s_last without s_vld is ignored.
- Reset mid-packet discards the output register contents and the grant. No partial-packet recovery is performed.

Decomposition:
- Shared package din_arb_pkg holds:
  - the arb_state_t enum (IDLE, GRANT);
  - the default DATA_W and MAX_BURST constants;
  - a function rr_pick(req, ptr) returning the winning index plus a found flag.
- One sub-module is natural: din_rr_picker, a combinational rotate/priority-encode/unrotate picker parameterised by N_SRC. It is reusable by other shared-resource arbiters.

Test Plan:
- Single source: s_vld[1]=1 with a 3-beat packet 0xA1, 0xA2, 0xA3 (last on 0xA3), rdy tied 1.
  - o_grant_id = 1 one cycle after request.
  - Output shows 0xA1..0xA3 on consecutive cycles, last only on 0xA3.
  - o_busy falls after the 0xA3 acceptance.
- All four sources requesting continuously with 1-beat packets from reset:
  - Grant order is 0, 1, 2, 3, 0, 1, …
  - One IDLE bubble between grants.
- MAX_BURST=4, source 2 sends a 10-beat packet while source 3 is requesting:
  - Beats 1–4 from source 2, forced last on beat 4, then source 3's packet, then source 2 resumes with beat 5.
- Backpressure: i_data_dout_rdy held low for 5 cycles mid-packet.
  - Output data is stable; s_rdy[g] = 0 while the register is full.
  - No beat is lost or duplicated; the scoreboard matches byte-for-byte.
- Granted source deasserts s_vld for 3 cycles mid-packet while source 0 requests:
  - The grant stays on the original source and source 0 is not served until that source's last.
- rst_n asserted while o_data_dout_vld = 1 mid-packet:
  - All outputs are 0 immediately (asynchronously).
  - After release, the first grant goes to the lowest-index requester.
